// File: rtl/hc08_tester.sv
// Exhaustive tester for one 74HC08 quad 2-input AND: walks all 256 {B,A} vectors,
// waits a settle time, compares the synchronized Y against A&B and reports the results.
module hc08_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic [4:1] o_a,
  output logic [4:1] o_b,
  input  logic [4:1] i_y,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [8:0] o_errCnt,
  output logic [4:1] o_failGate,
  output logic [7:0] o_firstFail
);

  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_badSettle
    $error("hc08_tester: SETTLE_CYCLES must be in 2..255");
  end

  localparam logic [7:0] LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, REPORT} state_t;

  state_t     r_state;
  logic [7:0] r_vec;
  logic [7:0] r_settleCnt;
  logic [4:1] r_a;
  logic [4:1] r_b;
  logic [4:1] r_ySync1;
  logic [4:1] r_ySync2;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [8:0] r_errCnt;
  logic [4:1] r_failGate;
  logic [7:0] r_firstFail;

  logic [4:1] w_mm;
  logic [8:0] w_errNext;
  logic [7:0] w_vecNext;

  // Y is only looked at in CHECK, by which time both sync stages hold the settled response
  assign w_mm      = r_ySync2 ^ (r_a & r_b);
  assign w_errNext = r_errCnt + {8'd0, (w_mm != 4'd0)};
  assign w_vecNext = r_vec + 8'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_vec       <= 8'd0;
      r_settleCnt <= 8'd0;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_ySync1    <= 4'd0;
      r_ySync2    <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_errCnt    <= 9'd0;
      r_failGate  <= 4'd0;
      r_firstFail <= 8'd0;
    end else begin
      r_ySync1 <= i_y;
      r_ySync2 <= r_ySync1;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= SETTLE;
            r_vec       <= 8'd0;
            r_settleCnt <= 8'd0;
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_errCnt    <= 9'd0;
            r_failGate  <= 4'd0;
            r_firstFail <= 8'd0;
          end
        end
        SETTLE: begin
          if (r_settleCnt == LAST_SETTLE) begin
            r_state <= CHECK;
          end else begin
            r_settleCnt <= r_settleCnt + 8'd1;
          end
        end
        CHECK: begin
          if (w_mm != 4'd0) begin
            r_errCnt   <= w_errNext;
            r_failGate <= r_failGate | w_mm;
            if (r_errCnt == 9'd0) begin
              r_firstFail <= r_vec;
            end
          end
          if (r_vec == 8'hFF) begin
            r_state <= REPORT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_errNext == 9'd0);
            r_a     <= 4'd0;
            r_b     <= 4'd0;
          end else begin
            r_state     <= SETTLE;
            r_vec       <= w_vecNext;
            r_settleCnt <= 8'd0;
            r_a         <= w_vecNext[3:0];
            r_b         <= w_vecNext[7:4];
          end
        end
        REPORT: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_errCnt    = r_errCnt;
  assign o_failGate  = r_failGate;
  assign o_firstFail = r_firstFail;

endmodule

// File: tb/tb_hc08_tester.sv
// Bench for hc08_tester: emulates a faulty or ideal 74HC08 and checks each run
// against a vector-by-vector model of what the tester should report.
module tb_hc08_tester;

  localparam int S       = 4;
  localparam int RUN_LAT = 256 * (S + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:1] a;
  logic [4:1] b;
  logic [4:1] y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] errCnt;
  logic [4:1] failGate;
  logic [7:0] firstFail;

  logic [4:1] stuck0 = 4'd0;
  logic [4:1] stuck1 = 4'd0;
  logic       swap24 = 1'b0;

  int checks = 0;
  int fails  = 0;

  hc08_tester #(.SETTLE_CYCLES(S)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_a(a), .o_b(b), .i_y(y),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_errCnt(errCnt), .o_failGate(failGate), .o_firstFail(firstFail)
  );

  always #5 clk = ~clk;

  // Device under test: an AND gate with optional stuck-at faults and a Y2/Y4 wiring swap
  function automatic logic [4:1] faultyY(input logic [4:1] fa, input logic [4:1] fb,
                                         input logic [4:1] s0, input logic [4:1] s1,
                                         input logic sw);
    logic [4:1] r;
    r = ((fa & fb) & ~s0) | s1;
    if (sw) r = {r[2], r[3], r[4], r[1]};
    return r;
  endfunction

  always_comb y = faultyY(a, b, stuck0, stuck1, swap24);

  // Expected report: walk every vector in order, as the tester is supposed to
  task automatic modelRun(output int expErr, output logic [4:1] expGate, output logic [7:0] expFirst);
    logic [7:0] v;
    logic [4:1] mm;
    expErr = 0; expGate = 4'd0; expFirst = 8'd0;
    for (int i = 0; i < 256; i++) begin
      v  = 8'(i);
      mm = faultyY(v[3:0], v[7:4], stuck0, stuck1, swap24) ^ (v[3:0] & v[7:4]);
      if (mm != 4'd0) begin
        if (expErr == 0) expFirst = v;
        expErr++;
        expGate |= mm;
      end
    end
  endtask

  // Pulses or holds START and returns cycles from the first BUSY cycle to DONE (-1 on timeout)
  task automatic runOnce(input bit holdStart, input int repulseAt, output int latency, output int busyCount);
    bit seen;
    seen = 0; busyCount = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    latency = 0;
    while (!seen && latency < RUN_LAT + 200) begin
      if (done) seen = 1;
      else begin
        if (busy) busyCount++;
        start = holdStart || (latency == repulseAt);
        @(negedge clk);
        latency++;
      end
    end
    if (!seen) latency = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a, b} !== 8'd0) begin fails++; $display("[TB] FAIL reset_ab: got %h expected 00", {a, b}); end
    checks++;
    if ({busy, done, pass} !== 3'b000) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, pass}); end
    checks++;
    if ({errCnt, failGate, firstFail} !== 21'd0) begin
      fails++; $display("[TB] FAIL reset_results: got err=%0d gate=%b first=%h expected all 0", errCnt, failGate, firstFail);
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    int lat, bc;
    stuck0 = 4'd0; stuck1 = 4'd0; swap24 = 1'b0;
    runOnce(0, -1, lat, bc);
    checks++;
    if (lat !== RUN_LAT) begin fails++; $display("[TB] FAIL ideal_latency: got %0d expected %0d", lat, RUN_LAT); end
    checks++;
    if (bc !== RUN_LAT) begin fails++; $display("[TB] FAIL ideal_busy_cycles: got %0d expected %0d", bc, RUN_LAT); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ideal_busy_in_report: got %b expected 0", busy); end
    checks++;
    if ({pass, errCnt, failGate, firstFail} !== {1'b1, 21'd0}) begin
      fails++; $display("[TB] FAIL ideal_result: got pass=%b err=%0d gate=%b first=%h expected 1/0/0000/00", pass, errCnt, failGate, firstFail);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin fails++; $display("[TB] FAIL ideal_done_pulse_width: got %b expected 0", done); end
    checks++;
    if (pass !== 1'b1) begin fails++; $display("[TB] FAIL ideal_pass_held: got %b expected 1", pass); end
  endtask

  task automatic test_plan_faults();
    int lat, bc;
    int expErr [3]   = '{64, 192, 96};
    logic [4:1] expGate [3] = '{4'b0100, 4'b0001, 4'b1010};
    logic [7:0] expFirst [3] = '{8'h44, 8'h00, 8'h22};
    for (int k = 0; k < 3; k++) begin
      stuck0 = (k == 0) ? 4'b0100 : 4'd0;
      stuck1 = (k == 1) ? 4'b0001 : 4'd0;
      swap24 = (k == 2);
      runOnce(0, -1, lat, bc);
      checks++;
      if (lat !== RUN_LAT) begin fails++; $display("[TB] FAIL fault%0d_latency: got %0d expected %0d", k, lat, RUN_LAT); end
      checks++;
      if (int'(errCnt) !== expErr[k]) begin fails++; $display("[TB] FAIL fault%0d_errcnt: got %0d expected %0d", k, errCnt, expErr[k]); end
      checks++;
      if (failGate !== expGate[k]) begin fails++; $display("[TB] FAIL fault%0d_gate: got %b expected %b", k, failGate, expGate[k]); end
      checks++;
      if ({pass, firstFail} !== {1'b0, expFirst[k]}) begin
        fails++; $display("[TB] FAIL fault%0d_pass_first: got pass=%b first=%h expected 0/%h", k, pass, firstFail, expFirst[k]);
      end
    end
  endtask

  task automatic test_random_faults();
    int lat, bc, eErr;
    logic [4:1] eGate;
    logic [7:0] eFirst;
    for (int k = 0; k < 3; k++) begin
      stuck0 = 4'($urandom_range(0, 15));
      stuck1 = 4'($urandom_range(0, 15)) & ~stuck0;
      swap24 = 1'($urandom_range(0, 1));
      modelRun(eErr, eGate, eFirst);
      runOnce(0, -1, lat, bc);
      checks++;
      if (lat !== RUN_LAT) begin fails++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", k, lat, RUN_LAT); end
      checks++;
      if (int'(errCnt) !== eErr) begin fails++; $display("[TB] FAIL rand%0d_errcnt: got %0d expected %0d", k, errCnt, eErr); end
      checks++;
      if ({failGate, firstFail} !== {eGate, eFirst}) begin
        fails++; $display("[TB] FAIL rand%0d_gate_first: got %b/%h expected %b/%h", k, failGate, firstFail, eGate, eFirst);
      end
      checks++;
      if (pass !== (eErr == 0)) begin fails++; $display("[TB] FAIL rand%0d_pass: got %b expected %b", k, pass, eErr == 0); end
    end
  endtask

  task automatic test_repulse();
    int lat, bc;
    stuck0 = 4'd0; stuck1 = 4'd0; swap24 = 1'b0;
    runOnce(0, 300, lat, bc);
    checks++;
    if (lat !== RUN_LAT) begin fails++; $display("[TB] FAIL repulse_latency: got %0d expected %0d", lat, RUN_LAT); end
    checks++;
    if (pass !== 1'b1) begin fails++; $display("[TB] FAIL repulse_pass: got %b expected 1", pass); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, n;
    stuck0 = 4'b0100; stuck1 = 4'd0; swap24 = 1'b0;
    runOnce(1, -1, lat, bc);
    checks++;
    if (lat !== RUN_LAT) begin fails++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, RUN_LAT); end
    @(negedge clk);
    checks++;
    if ({busy, pass, errCnt} !== {1'b0, 1'b0, 9'd64}) begin
      fails++; $display("[TB] FAIL b2b_idle_held: got busy=%b pass=%b err=%0d expected 0/0/64", busy, pass, errCnt);
    end
    stuck0 = 4'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_restart_busy: got %b expected 1", busy); end
    checks++;
    if ({errCnt, failGate, firstFail, pass} !== 22'd0) begin
      fails++; $display("[TB] FAIL b2b_cleared: got err=%0d gate=%b first=%h pass=%b expected all 0", errCnt, failGate, firstFail, pass);
    end
    n = 0;
    while (!done && n < RUN_LAT + 200) begin @(negedge clk); n++; end
    checks++;
    if (n !== RUN_LAT) begin fails++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", n, RUN_LAT); end
    checks++;
    if (pass !== 1'b1) begin fails++; $display("[TB] FAIL b2b_second_pass: got %b expected 1", pass); end
  endtask

  task automatic test_mid_reset();
    int n, doneCnt, busyCnt, lat, bc;
    stuck0 = 4'b0010; stuck1 = 4'd0; swap24 = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while ({b, a} != 8'd100 && n < RUN_LAT) begin @(negedge clk); n++; end
    checks++;
    if ({b, a} !== 8'd100) begin fails++; $display("[TB] FAIL midrst_reach_vec100: got %h expected 64", {b, a}); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a, b, busy, done, pass, errCnt, failGate, firstFail} !== 32'd0) begin
      fails++; $display("[TB] FAIL midrst_outputs: got ab=%h busy=%b done=%b pass=%b err=%0d gate=%b first=%h expected all 0",
                        {a, b}, busy, done, pass, errCnt, failGate, firstFail);
    end
    doneCnt = 0; busyCnt = 0;
    for (int i = 0; i < RUN_LAT + 50; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
      if (busy) busyCnt++;
    end
    checks++;
    if (doneCnt !== 0) begin fails++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", doneCnt); end
    checks++;
    if (busyCnt !== 0) begin fails++; $display("[TB] FAIL midrst_stays_idle: got %0d busy cycles expected 0", busyCnt); end
    stuck0 = 4'd0;
    runOnce(0, -1, lat, bc);
    checks++;
    if ({lat == RUN_LAT, pass, errCnt} !== {1'b1, 1'b1, 9'd0}) begin
      fails++; $display("[TB] FAIL midrst_rerun: got lat=%0d pass=%b err=%0d expected %0d/1/0", lat, pass, errCnt, RUN_LAT);
    end
  endtask

  initial begin
    start = 1'b0;
    rst   = 1'b1;
    test_reset();
    test_ideal();
    test_plan_faults();
    test_random_faults();
    test_repulse();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
